// File: rtl/gray_counter_pkg.sv
// Shared constants and Gray-code helpers for the gray_counter block.
// gray2bin is intended for checking code.
package gray_counter_pkg;

  localparam int GRAY_WIDTH_DEFAULT = 3;
  localparam int GRAY_MAX_WIDTH     = 32;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
    logic [GRAY_MAX_WIDTH-1:0] bin;
    bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_counter_encode.sv
// Purely combinational binary-to-Gray converter.
module gray_encode #(
  parameter int WIDTH = gray_counter_pkg::GRAY_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // The MSB passes through; every lower bit is the XOR of itself and its upper neighbour.
  assign gray[WIDTH-1] = bin[WIDTH-1];

  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
      assign gray[gi] = bin[gi] ^ bin[gi+1];
    end
  endgenerate

endmodule

// File: rtl/gray_counter.sv
// Gray-code counter with count enable and a sticky wrap flag.
// A binary count is kept internally; the Gray output is registered from the next count.
module gray_counter #(
  parameter int WIDTH = gray_counter_pkg::GRAY_WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  output logic [WIDTH-1:0] Output,
  output logic             Overflow
);

  logic [WIDTH-1:0] bin_reg;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_reg;
  logic [WIDTH-1:0] gray_next;
  logic             ovf_reg;
  logic             wrap;

  assign bin_next = bin_reg + 1'b1;
  assign wrap     = &bin_reg;

  gray_encode #(
    .WIDTH(WIDTH)
  ) u_encode (
    .bin  (bin_next),
    .gray (gray_next)
  );

  // Encoding the next count keeps Output in step with bin_reg on the same edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bin_reg  <= '0;
      gray_reg <= '0;
      ovf_reg  <= 1'b0;
    end else if (En) begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      if (wrap) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  assign Output   = gray_reg;
  assign Overflow = ovf_reg;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: a 3-bit instance driven from a vector table
// and a 4-bit instance walked through a full wrap.
module tb_gray_counter;
  import gray_counter_pkg::*;

  typedef struct {
    logic       en;
    logic [2:0] out;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [3:0] out;
    logic       ovf;
  } exp_t;

  logic       Clk;
  logic       reset3, en3, ovf3;
  logic [2:0] out3;
  logic       reset4, en4, ovf4;
  logic [3:0] out4;

  int n_vec;
  int n_err;
  exp_t sb[$];
  vec_t vecs[25];

  gray_counter #(.WIDTH(3)) dut3 (
    .Clk      (Clk),
    .Reset    (reset3),
    .En       (en3),
    .Output   (out3),
    .Overflow (ovf3)
  );

  gray_counter #(.WIDTH(4)) dut4 (
    .Clk      (Clk),
    .Reset    (reset4),
    .En       (en4),
    .Output   (out4),
    .Overflow (ovf4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic [2:0] out, input logic ovf);
    vec_t v;
    v.en  = en;
    v.out = out;
    v.ovf = ovf;
    return v;
  endfunction

  initial begin
    logic [2:0]  prev3;
    logic [3:0]  prev4;
    logic [3:0]  b4;
    logic [15:0] seen;
    exp_t        e;

    n_vec = 0;
    n_err = 0;

    // First lap, wrap, second lap.
    vecs[0]  = mk(1'b1, 3'b001, 1'b0);
    vecs[1]  = mk(1'b1, 3'b011, 1'b0);
    vecs[2]  = mk(1'b1, 3'b010, 1'b0);
    vecs[3]  = mk(1'b1, 3'b110, 1'b0);
    vecs[4]  = mk(1'b1, 3'b111, 1'b0);
    vecs[5]  = mk(1'b1, 3'b101, 1'b0);
    vecs[6]  = mk(1'b1, 3'b100, 1'b0);
    vecs[7]  = mk(1'b1, 3'b000, 1'b1);
    vecs[8]  = mk(1'b1, 3'b001, 1'b1);
    vecs[9]  = mk(1'b1, 3'b011, 1'b1);
    vecs[10] = mk(1'b1, 3'b010, 1'b1);
    vecs[11] = mk(1'b1, 3'b110, 1'b1);
    vecs[12] = mk(1'b1, 3'b111, 1'b1);
    vecs[13] = mk(1'b1, 3'b101, 1'b1);
    vecs[14] = mk(1'b1, 3'b100, 1'b1);
    vecs[15] = mk(1'b1, 3'b000, 1'b1);
    // Advance to 011, hold for five cycles, then resume.
    vecs[16] = mk(1'b1, 3'b001, 1'b1);
    vecs[17] = mk(1'b1, 3'b011, 1'b1);
    vecs[18] = mk(1'b0, 3'b011, 1'b1);
    vecs[19] = mk(1'b0, 3'b011, 1'b1);
    vecs[20] = mk(1'b0, 3'b011, 1'b1);
    vecs[21] = mk(1'b0, 3'b011, 1'b1);
    vecs[22] = mk(1'b0, 3'b011, 1'b1);
    vecs[23] = mk(1'b1, 3'b010, 1'b1);
    vecs[24] = mk(1'b1, 3'b110, 1'b1);

    reset3 = 1'b0;
    en3    = 1'b0;
    reset4 = 1'b0;
    en4    = 1'b0;

    // Held in reset for ten cycles.
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk);
      #1;
      check("reset_out3", {29'd0, out3}, 32'd0);
      check("reset_ovf3", {31'd0, ovf3}, 32'd0);
      $display("reset cycle %0d: out3=%b ovf3=%b", c, out3, ovf3);
    end

    reset3 = 1'b1;
    prev3  = out3;
    for (int i = 0; i < 25; i++) begin
      en3 = vecs[i].en;
      sb.push_back('{out: {1'b0, vecs[i].out}, ovf: vecs[i].ovf});
      @(posedge Clk);
      #1;
      e = sb.pop_front();
      check("table_out3", {29'd0, out3}, {28'd0, e.out});
      check("table_ovf3", {31'd0, ovf3}, {31'd0, e.ovf});
      if (vecs[i].en) begin
        check("one_bit_step3", $countones(prev3 ^ out3), 32'd1);
      end
      $display("vec %0d: en=%b out3=%b ovf3=%b (req %b/%b)", i, vecs[i].en, out3, ovf3, e.out[2:0], e.ovf);
      prev3 = out3;
    end

    // Asynchronous reset between edges while at 110 with the flag set.
    #2;
    reset3 = 1'b0;
    #1;
    check("async_rst_out3", {29'd0, out3}, 32'd0);
    check("async_rst_ovf3", {31'd0, ovf3}, 32'd0);
    $display("async reset: out3=%b ovf3=%b", out3, ovf3);
    en3 = 1'b1;
    @(posedge Clk);
    #1;
    check("rst_held_out3", {29'd0, out3}, 32'd0);
    $display("reset held over enabled edge: out3=%b", out3);
    reset3 = 1'b1;
    sb.push_back('{out: 4'b0001, ovf: 1'b0});
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check("restart_out3", {29'd0, out3}, {28'd0, e.out});
    check("restart_ovf3", {31'd0, ovf3}, {31'd0, e.ovf});
    $display("restart: out3=%b ovf3=%b", out3, ovf3);
    en3 = 1'b0;

    // Four-bit instance: a full lap of sixteen enabled edges.
    reset4 = 1'b1;
    @(posedge Clk);
    #1;
    check("w4_start_out", {28'd0, out4}, 32'd0);
    prev4 = out4;
    b4    = 4'd0;
    seen  = 16'h0001;
    for (int k = 1; k <= 16; k++) begin
      en4 = 1'b1;
      b4  = b4 + 4'd1;
      sb.push_back('{out: b4 ^ (b4 >> 1), ovf: (k == 16)});
      @(posedge Clk);
      #1;
      e = sb.pop_front();
      check("w4_out", {28'd0, out4}, {28'd0, e.out});
      check("w4_ovf", {31'd0, ovf4}, {31'd0, e.ovf});
      check("w4_one_bit", $countones(prev4 ^ out4), 32'd1);
      check("w4_decode", gray2bin({28'd0, out4}), {28'd0, b4});
      if (k < 16) begin
        check("w4_distinct", {31'd0, seen[out4]}, 32'd0);
        seen[out4] = 1'b1;
      end
      $display("w4 edge %0d: out4=%b ovf4=%b (req %b/%b)", k, out4, ovf4, e.out, e.ovf);
      prev4 = out4;
    end
    en4 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Synchronous Gray-code counter with an enable input and a sticky overflow flag.
- Default width is 3 bits.
- Serves as a small sequencing/state-code generator where only one output bit may toggle per step.
- Internally keeps a binary count and presents its Gray-code equivalent as a registered output.

Parameters:
- WIDTH, 3, counter width in bits (must be >= 2)

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset (logic 0 = reset asserted)
- En  input  1  count enable, sampled on rising Clk
- Output  output  WIDTH  current Gray-code count, registered
- Overflow  output  1  sticky wrap flag, registered

Behaviour:
- One clock domain (Clk). Reset is asynchronous and active-low; the port is named Reset.
- Reset asserted (Reset=0): immediately, without waiting for a clock edge:
  - internal binary count = 0
  - Output = 0
  - Overflow = 0
- Reset release is synchronous in effect. The first count can occur on the first rising Clk edge where Reset=1 and En=1.
- Rising Clk, Reset=1, En=1:
  - binary count increments modulo 2^WIDTH
  - Output = next_bin XOR (next_bin >> 1)
- Latency: Output reflects the new count in the same cycle as the edge. Output is a register, never driven combinationally from the inputs.
- Rising Clk, Reset=1, En=0: count, Output and Overflow all hold.
- Sequence for WIDTH=3: 000, 001, 011, 010, 110, 111, 101, 100, then back to 000.
- Exactly one Output bit changes per enabled step, including the 100 -> 000 wrap.
- Wrap: on an enabled edge where binary count = 2^WIDTH-1 (Output = 100 for WIDTH=3):
  - count goes to 0 and Output goes to 000
  - Overflow is set to 1 on that same edge
- Overflow is sticky. It stays 1 across further counting and further wraps, and across En=0. Only reset clears it.
- Reset mid-count: Output and Overflow return to 0 at once, whatever the clock phase. Counting restarts from 000 after release.
- En and Reset are assumed synchronous to Clk for En. Reset may be asserted at any time. Deassertion must meet recovery/removal timing.
- No X propagation: all registers have defined reset values.

Decomposition:
- Shared package holds:
  - default width constant GRAY_WIDTH_DEFAULT = 3
  - a function bin2gray(bin) = bin ^ (bin >> 1)
  - a function gray2bin for verification use
- One natural sub-module: gray_encode, a purely combinational binary-to-Gray converter parameterized by WIDTH.
- Top level holds:
  - binary counter register
  - Output register fed by gray_encode of the next count
  - Overflow sticky register

Test Plan:
- Reset=0, En=0 for 10 cycles -> Output=000, Overflow=0 throughout, no X.
- Release reset, En=1 for 7 edges -> Output steps 001, 011, 010, 110, 111, 101, 100; Overflow=0; Hamming distance 1 per step.
- Continue one more enabled edge -> Output=000 and Overflow=1 on the same edge. Run 8 more edges -> sequence repeats, Overflow stays 1.
- From Output=011, drop En for 5 cycles -> Output holds 011, Overflow unchanged. Re-enable -> next value 010.
- Assert Reset=0 mid-cycle (between edges) while Output=110 and Overflow=1 -> both go to 0 immediately. After release plus one enabled edge, Output=001.
- WIDTH=4 instance: 16 enabled edges from reset -> 16 distinct Gray codes, each step changes one bit. The 16th edge returns Output=0000 and sets Overflow=1.
